// File: rtl/cmd_packet_rx_if.sv
// Host byte stream in, decoded command frame out, for cmd_packet_rx.
interface cmd_packet_rx_if #(
    parameter int unsigned PACKET_SIZE = 256
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [7:0]               cmd_opcode;
    logic [7:0]               cmd_len;
    logic [8*PACKET_SIZE-1:0] cmd_packet;
    logic                     crc_err;
    logic                     frame_err;
    logic [15:0]              pkt_count;
    logic [15:0]              err_count;

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output rx_ready, cmd_valid, cmd_opcode, cmd_len, cmd_packet,
               crc_err, frame_err, pkt_count, err_count
    );

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  rx_ready, cmd_valid, cmd_opcode, cmd_len, cmd_packet,
               crc_err, frame_err, pkt_count, err_count
    );
endinterface

// File: rtl/cmd_packet_rx.sv
// SYNC/LEN framed byte-stream receiver with CRC-8 (poly 0x07) check and
// valid/ready hand-off of the captured packet image to the command dispatcher.
module cmd_packet_rx #(
    parameter int unsigned PACKET_SIZE    = 256,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA
) (
    input logic            CLK,
    input logic            rst,
    cmd_packet_rx_if.slave bus
);
    localparam int unsigned PKT_W = 8 * PACKET_SIZE;
    localparam int unsigned IDX_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_BODY,
        S_CHK,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PKT_W-1:0] r_packet;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [7:0]       r_crc;
    logic [7:0]       w_crc_next;
    logic [TO_W-1:0]  r_idle;
    logic             r_rx_ready;
    logic             r_cmd_valid;
    logic             r_crc_err;
    logic             r_frame_err;
    logic [15:0]      r_pkt_count;
    logic [15:0]      r_err_count;

    logic             w_accept;
    logic             w_timeout;
    logic             w_in_frame;
    logic             w_len_ok;
    logic             w_at_len;
    logic [7:0]       w_crc_fold;
    logic             w_sync_start;
    logic             w_store;
    logic             w_crc_err;
    logic             w_frame_err;
    logic             w_handshake;

    // One byte of CRC-8, polynomial 0x07, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign w_accept   = bus.rx_valid && r_rx_ready;
    assign w_timeout  = (r_idle == TO_W'(TIMEOUT_CYCLES));
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_BODY) || (r_state == S_CHK);
    assign w_crc_fold = crc8_byte(r_crc, bus.rx_data);
    assign w_len_ok   = (bus.rx_data != 8'd0) &&
                        ((32'(bus.rx_data) + 32'd2) <= 32'(PACKET_SIZE));
    assign w_at_len   = (32'(r_idx) == 32'(r_packet[15:8]));

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus datapath strobes; a timeout outranks a byte in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_crc_next   = r_crc;
        w_sync_start = 1'b0;
        w_store      = 1'b0;
        w_crc_err    = 1'b0;
        w_frame_err  = 1'b0;
        w_handshake  = 1'b0;
        unique case (r_state)
            S_HUNT: begin
                if (w_accept && (bus.rx_data == SYNC_BYTE)) begin
                    w_sync_start = 1'b1;
                    w_crc_next   = 8'h00;
                    w_idx_next   = IDX_W'(1);
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_timeout) begin
                    w_frame_err  = 1'b1;
                    w_state_next = S_HUNT;
                end else if (w_accept) begin
                    if (!w_len_ok) begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_HUNT;
                    end else begin
                        w_store      = 1'b1;
                        w_crc_next   = w_crc_fold;
                        w_idx_next   = IDX_W'(2);
                        w_state_next = (bus.rx_data == 8'd1) ? S_CHK : S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (w_timeout) begin
                    w_frame_err  = 1'b1;
                    w_state_next = S_HUNT;
                end else if (w_accept) begin
                    w_store    = 1'b1;
                    w_crc_next = w_crc_fold;
                    w_idx_next = r_idx + IDX_W'(1);
                    if (w_at_len) begin
                        w_state_next = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (w_timeout) begin
                    w_frame_err  = 1'b1;
                    w_state_next = S_HUNT;
                end else if (w_accept) begin
                    w_store = 1'b1;
                    if (bus.rx_data == r_crc) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_crc_err    = 1'b1;
                        w_state_next = S_HUNT;
                    end
                end
            end
            S_DONE: begin
                if (bus.cmd_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_HUNT;
                end
            end
            default: begin
                w_state_next = S_HUNT;
            end
        endcase
    end

    // Packet image, byte index and running CRC.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_packet <= '0;
            r_idx    <= '0;
            r_crc    <= 8'h00;
        end else begin
            r_idx <= w_idx_next;
            r_crc <= w_crc_next;
            if (w_sync_start) begin
                r_packet <= PKT_W'(SYNC_BYTE);
            end else if (w_store) begin
                r_packet[{r_idx, 3'b000} +: 8] <= bus.rx_data;
            end
        end
    end

    // Inter-byte idle counter, only live while a frame is being collected.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_idle <= '0;
        end else if (!w_in_frame || w_accept || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + TO_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_rx_ready  <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_pkt_count <= 16'h0000;
            r_err_count <= 16'h0000;
        end else begin
            r_rx_ready  <= (w_state_next != S_DONE);
            r_cmd_valid <= (w_state_next == S_DONE);
            r_crc_err   <= w_crc_err;
            r_frame_err <= w_frame_err;
            if (w_handshake && (r_pkt_count != 16'hFFFF)) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if ((w_crc_err || w_frame_err) && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.cmd_len    = r_packet[15:8];
    assign bus.cmd_opcode = r_packet[23:16];
    assign bus.cmd_packet = r_packet;
    assign bus.crc_err    = r_crc_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.pkt_count  = r_pkt_count;
    assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_cmd_packet_rx.sv
// Directed bench for cmd_packet_rx: frame-level reference model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_cmd_packet_rx;
    localparam int unsigned PS   = 256;
    localparam int unsigned TO   = 16;
    localparam logic [7:0]  SYNC = 8'hAA;

    typedef logic [7:0] byte_q_t[$];

    logic CLK;
    logic rst;

    cmd_packet_rx_if #(.PACKET_SIZE(PS)) bus ();

    cmd_packet_rx #(
        .PACKET_SIZE   (PS),
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (SYNC)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: bytes of the frame in progress, idle cycles, done flag.
    byte_q_t       m_q;
    bit            m_done;
    int            m_idle;
    logic [15:0]   m_pkt_cnt;
    logic [15:0]   m_err_cnt;
    logic [8*PS-1:0] m_pkt;
    bit            exp_crc_err;
    bit            exp_frame_err;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [7:0] crc8_q(input byte_q_t q, input int first, input int last);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int i = first; i <= last; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ q[i][b];
                crc = {crc[6:0], 1'b0};
                if (fb) crc = crc ^ 8'h07;
            end
        end
        return crc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_pkt(input string name, input logic [8*PS-1:0] act, input logic [8*PS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int i = 0; i < PS; i++) begin
                if (act[8*i +: 8] !== exp[8*i +: 8]) begin
                    $display("FAIL %s: byte %0d got %0h expected %0h (t=%0t)",
                             name, i, act[8*i +: 8], exp[8*i +: 8], $time);
                    break;
                end
            end
        end
    endtask

    task automatic model_frame_err();
        exp_frame_err = 1'b1;
        if (m_err_cnt != 16'hFFFF) m_err_cnt++;
        m_q.delete();
        m_idle = 0;
    endtask

    task automatic model_step();
        int len;
        exp_crc_err   = 1'b0;
        exp_frame_err = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_done    = 1'b0;
            m_idle    = 0;
            m_pkt_cnt = 16'h0000;
            m_err_cnt = 16'h0000;
            m_pkt     = '0;
            return;
        end
        if (m_done) begin
            if (bus.cmd_ready) begin
                m_done = 1'b0;
                m_q.delete();
                if (m_pkt_cnt != 16'hFFFF) m_pkt_cnt++;
            end
            return;
        end
        if (m_q.size() != 0 && m_idle == TO) begin
            model_frame_err();
            return;
        end
        if (bus.rx_valid) begin
            m_idle = 0;
            if (m_q.size() == 0) begin
                if (bus.rx_data == SYNC) m_q.push_back(bus.rx_data);
            end else begin
                m_q.push_back(bus.rx_data);
                len = int'(m_q[1]);
                if (m_q.size() == 2) begin
                    if (len == 0 || len + 2 > PS) model_frame_err();
                end else if (m_q.size() == len + 2) begin
                    if (crc8_q(m_q, 1, len) == m_q[len + 1]) begin
                        m_done = 1'b1;
                        m_pkt  = '0;
                        foreach (m_q[i]) m_pkt[8*i +: 8] = m_q[i];
                    end else begin
                        exp_crc_err = 1'b1;
                        if (m_err_cnt != 16'hFFFF) m_err_cnt++;
                        m_q.delete();
                    end
                end
            end
        end else if (m_q.size() != 0) begin
            m_idle++;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge rst);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (!rst) begin
                chk("rst rx_ready", 64'(bus.rx_ready), 64'd1);
                chk("rst cmd_valid", 64'(bus.cmd_valid), 64'd0);
                chk("rst crc_err", 64'(bus.crc_err), 64'd0);
                chk("rst frame_err", 64'(bus.frame_err), 64'd0);
                chk("rst pkt_count", 64'(bus.pkt_count), 64'd0);
                chk("rst err_count", 64'(bus.err_count), 64'd0);
                chk("rst cmd_opcode", 64'(bus.cmd_opcode), 64'd0);
                chk("rst cmd_len", 64'(bus.cmd_len), 64'd0);
                chk_pkt("rst cmd_packet", bus.cmd_packet, '0);
            end else begin
                chk("rx_ready", 64'(bus.rx_ready), 64'(!m_done));
                chk("cmd_valid", 64'(bus.cmd_valid), 64'(m_done));
                chk("crc_err", 64'(bus.crc_err), 64'(exp_crc_err));
                chk("frame_err", 64'(bus.frame_err), 64'(exp_frame_err));
                chk("pkt_count", 64'(bus.pkt_count), 64'(m_pkt_cnt));
                chk("err_count", 64'(bus.err_count), 64'(m_err_cnt));
                if (m_done) begin
                    chk("cmd_opcode", 64'(bus.cmd_opcode), 64'(m_pkt[23:16]));
                    chk("cmd_len", 64'(bus.cmd_len), 64'(m_pkt[15:8]));
                    chk_pkt("cmd_packet", bus.cmd_packet, m_pkt);
                end
            end
        end
    end

    task automatic send(input byte_q_t q);
        foreach (q[i]) begin
            @(negedge CLK);
            bus.rx_data  = q[i];
            bus.rx_valid = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'h00;
        end
    endtask

    task automatic wait_valid(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            bus.rx_valid = 1'b0;
            if (bus.cmd_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: cmd_valid not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge CLK);
        #2 rst = 1'b0;
        repeat (cycles) @(posedge CLK);
        #2 rst = 1'b1;
    endtask

    initial begin
        byte_q_t    q;
        logic [8*PS-1:0] snap;
        logic [8*PS-1:0] lit;

        rst           = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #2 rst = 1'b1;

        q = '{8'h02, 8'h05};
        chk("model crc 02 05", 64'(crc8_q(q, 0, 1)), 64'h31);

        // Minimum frame, dispatcher always ready.
        bus.cmd_ready = 1'b1;
        q = '{8'hAA, 8'h02, 8'h05, 8'h31};
        send(q);
        wait_valid("min frame", 8);
        chk("min opcode", 64'(bus.cmd_opcode), 64'h05);
        chk("min len", 64'(bus.cmd_len), 64'h02);
        lit = '0;
        lit[31:0] = 32'h3105_02AA;
        chk_pkt("min packet", bus.cmd_packet, lit);
        idle(1);
        chk("min valid drop", 64'(bus.cmd_valid), 64'd0);
        chk("min pkt_count", 64'(bus.pkt_count), 64'd1);

        // Bad CRC then recovery.
        q = '{8'hAA, 8'h02, 8'h05, 8'h32};
        send(q);
        idle(3);
        chk("badcrc err_count", 64'(bus.err_count), 64'd1);
        chk("badcrc pkt_count", 64'(bus.pkt_count), 64'd1);
        q = '{8'hAA, 8'h02, 8'h05, 8'h31};
        send(q);
        idle(3);
        chk("recover pkt_count", 64'(bus.pkt_count), 64'd2);

        // Garbage before SYNC, LEN=0 and oversize LEN.
        q = '{8'h00, 8'h13, 8'hAA, 8'h00};
        send(q);
        idle(3);
        chk("len0 err_count", 64'(bus.err_count), 64'd2);
        q = '{8'hAA, 8'hFF};
        send(q);
        idle(3);
        chk("lenff err_count", 64'(bus.err_count), 64'd3);

        // LEN=1: the CRC byte directly follows LEN.
        q = '{8'hAA, 8'h01, 8'h07};
        send(q);
        wait_valid("len1 frame", 8);
        chk("len1 opcode", 64'(bus.cmd_opcode), 64'h07);
        idle(2);
        chk("len1 pkt_count", 64'(bus.pkt_count), 64'd3);

        // LOAD_VERTEX frame under backpressure, a SYNC-valued body byte included.
        bus.cmd_ready = 1'b0;
        q = '{8'hAA, 8'h15, 8'h03, 8'h02, 8'h00, 8'h10,
              8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'h66, 8'h77, 8'h88,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        q.push_back(crc8_q(q, 1, 21));
        send(q);
        wait_valid("bp frame", 8);
        snap = bus.cmd_packet;
        chk("bp len", 64'(bus.cmd_len), 64'h15);
        chk("bp opcode", 64'(bus.cmd_opcode), 64'h03);
        idle(25);
        q = '{8'hAA};
        send(q);
        idle(25);
        chk("bp hold valid", 64'(bus.cmd_valid), 64'd1);
        chk("bp hold rx_ready", 64'(bus.rx_ready), 64'd0);
        chk_pkt("bp hold packet", bus.cmd_packet, snap);
        bus.cmd_ready = 1'b1;
        idle(1);
        chk("bp release valid", 64'(bus.cmd_valid), 64'd0);
        chk("bp release rx_ready", 64'(bus.rx_ready), 64'd1);
        chk("bp pkt_count", 64'(bus.pkt_count), 64'd4);

        // Timeout after 16 idle cycles, then a frame that survives 15 idle cycles.
        q = '{8'hAA, 8'h05, 8'h03};
        send(q);
        idle(16);
        chk("to err before", 64'(bus.err_count), 64'd3);
        idle(3);
        chk("to err_count", 64'(bus.err_count), 64'd4);
        q = '{8'hAA, 8'h02, 8'h05};
        send(q);
        idle(15);
        q = '{8'h31};
        send(q);
        wait_valid("idle15 frame", 8);
        idle(1);
        chk("idle15 pkt_count", 64'(bus.pkt_count), 64'd5);
        q = '{8'hAA, 8'h02, 8'h05, 8'h31};
        send(q);
        idle(3);
        chk("post-to pkt_count", 64'(bus.pkt_count), 64'd6);

        // Reset in the middle of a frame.
        q = '{8'hAA, 8'h05};
        send(q);
        idle(1);
        do_reset(3);
        idle(1);
        chk("rst2 pkt_count", 64'(bus.pkt_count), 64'd0);
        chk_pkt("rst2 packet", bus.cmd_packet, '0);
        q = '{8'hAA, 8'h02, 8'h05, 8'h31};
        send(q);
        wait_valid("post-reset frame", 8);
        chk("post-reset opcode", 64'(bus.cmd_opcode), 64'h05);
        idle(2);
        chk("post-reset pkt_count", 64'(bus.pkt_count), 64'd1);
        chk("post-reset err_count", 64'(bus.err_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmd_packet_rx.md
# cmd_packet_rx

Byte-stream packet receiver that sits directly upstream of the LOAD_VERTEX command stage.
- It hunts for the SYNC byte in the host byte stream (UART RX side) and captures the LEN-delimited frame into a flat packet register.
- It checks the length and the CRC-8.
- It presents each good frame (opcode, LEN, full packet image) to the command dispatcher with a valid/ready handshake; the dispatcher converts the accepted frame into `begin_req_pulse`/`begin_len`/`begin_packet` for the target command stage.

## Interface
- `PACKET_SIZE`, 256: packet buffer size in bytes. A frame occupies LEN+2 bytes (SYNC and LEN plus LEN further bytes).
- `TIMEOUT_CYCLES`, 100000: maximum idle cycles between bytes inside a frame before the frame is abandoned.
- `SYNC_BYTE`, 8'hAA: frame start marker.

Ports:
- `CLK`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `rx_data`  input  8  incoming byte.
- `rx_valid`  input  1  `rx_data` is valid this cycle.
- `rx_ready`  output  1  block can accept a byte. A byte transfers on `rx_valid && rx_ready`.
- `cmd_valid`  output  1  complete, CRC-clean frame available.
- `cmd_ready`  input  1  dispatcher accepts the frame. Transfer on `cmd_valid && cmd_ready`.
- `cmd_opcode`  output  8  packet byte 2.
- `cmd_len`  output  8  packet byte 1 (LEN).
- `cmd_packet`  output  8*PACKET_SIZE  byte i at bits [8i+7:8i]. Byte 0 is SYNC; bytes above LEN+1 are zero.
- `crc_err`  output  1  one-cycle pulse: CRC mismatch.
- `frame_err`  output  1  one-cycle pulse: bad LEN or inter-byte timeout.
- `pkt_count`  output  16  good frames accepted by the dispatcher; saturates at 16'hFFFF.
- `err_count`  output  16  `crc_err` plus `frame_err` events; saturating.

## Operation
- Frame layout, by byte index:
  - 0: SYNC
  - 1: LEN
  - 2: opcode
  - 3 .. LEN: body
  - LEN+1: CRC
- LEN counts all bytes after the LEN byte, CRC included. Example: LOAD_VERTEX with N vertices has LEN = 5+8N.
- CRC: CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR. It covers bytes 1..LEN (LEN byte through last body byte). SYNC and the CRC byte are excluded.
- States:
  - HUNT: discard bytes until one equals SYNC_BYTE. On SYNC: clear `cmd_packet` to zero, store byte 0, clear CRC, go to LEN.
  - LEN: on byte accept, check the value. LEN==0 or LEN+2 > PACKET_SIZE: pulse `frame_err`, go to HUNT. Otherwise store it at index 1, fold it into the CRC, set the byte index to 2, go to BODY; if LEN==1, go directly to CHK.
  - BODY: store each byte at the current index and fold it into the CRC. When index == LEN is stored, go to CHK.
  - CHK: the next byte is the CRC. Store it at index LEN+1. If it equals the running CRC, go to DONE; else pulse `crc_err` and go to HUNT.
  - DONE: `cmd_valid`=1 and `rx_ready`=0. Outputs are held stable until `cmd_ready`. On handshake: increment `pkt_count`, go to HUNT.
- Timeout: an idle counter runs in LEN/BODY/CHK and resets on every accepted byte. When it reaches TIMEOUT_CYCLES: pulse `frame_err`, go to HUNT. Partial data is discarded.
- A SYNC_BYTE value inside BODY/CHK is ordinary data; there is no resynchronisation mid-frame.
- `err_count` increments on every `crc_err` or `frame_err` pulse.

## Timing
- Reset values: state HUNT, `rx_ready`=1, `cmd_valid`=0, `cmd_opcode`=0, `cmd_len`=0, `cmd_packet`=0, `crc_err`=0, `frame_err`=0, both counters 0, idle counter 0.
- `rx_ready` is 1 in HUNT/LEN/BODY/CHK and 0 in DONE. It is registered; no combinational path from `rx_valid`.
- One byte per cycle is sustainable. The CRC update is single-cycle, byte-wide.
- `cmd_valid` rises on the cycle after the CRC byte is accepted. `crc_err` pulses on that same cycle.
- `frame_err` pulses on the cycle after the offending LEN byte is accepted, or on the cycle after the counter reaches TIMEOUT_CYCLES.
- `cmd_ready` may be high before `cmd_valid`; the transfer happens on the first cycle both are high. State is HUNT and `rx_ready`=1 on the next cycle.
- `cmd_ready` is ignored outside DONE.
- Reset asserted mid-frame: all state and outputs return to reset values immediately; the partial frame is lost.
- Counter saturation: at 16'hFFFF a further event leaves the count unchanged.

## Test plan
- Min frame: send AA 02 05 31 back-to-back with `cmd_ready`=1 -> `cmd_valid` for 1 cycle, `cmd_opcode`=05, `cmd_len`=02, packet bytes 0..3 = AA 02 05 31 and the rest zero, `pkt_count`=1.
- Bad CRC: send AA 02 05 32 -> `crc_err` pulse, no `cmd_valid`, `err_count`=1. A following AA 02 05 31 is accepted normally.
- Garbage/length: send 00 13 AA 00 -> leading bytes discarded, then `frame_err` (LEN=0). Repeat with LEN=FF and PACKET_SIZE=256 -> `frame_err`.
- Backpressure: send a LOAD_VERTEX frame (LEN=0x15, opcode 03, count 02, start 0010, two vertices, model CRC) with `cmd_ready`=0 for 50 cycles -> `cmd_valid` and the outputs stay stable, `rx_ready`=0. Raise `cmd_ready` -> single transfer, then `rx_ready`=1.
- Timeout: TIMEOUT_CYCLES=16; send AA 05 03 then idle 16 cycles -> `frame_err`, state HUNT. The next valid frame is accepted.
- Reset mid-frame: drop `rst` after AA 05 -> all outputs at reset values; the following AA 02 05 31 is received correctly.
